// File: rtl/hdmi_pll_supervisor.sv
// Supervises the HDMI pixel-clock PLL: sequences its reset, qualifies lock, and gates the downstream reset.
// Define HDMI_PLL_SUP_LOSS_CNT_EN to build the lock-loss counter; otherwise loss_cnt is tied to zero.
module hdmi_pll_supervisor #(
    parameter int RST_CYCLES    = 32,
    parameter int LOCK_TIMEOUT  = 270000,
    parameter int STABLE_CYCLES = 2700,
    parameter int DROP_FILTER   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       hdmi_rst,
    output logic       sup_locked,
    output logic [1:0] sup_state,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    typedef struct packed {
        logic pll_rst;
        logic hdmi_rst;
        logic sup_locked;
    } flags_t;

    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > DROP_FILTER) ? STABLE_CYCLES : DROP_FILTER;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] DROP_LAST    = CW'(DROP_FILTER - 1);

    // Output flags are a pure function of the state being entered, so they register alongside it.
    function automatic flags_t flags_for(input state_t s);
        return '{pll_rst: (s == RESET_PLL), hdmi_rst: (s != RUN), sup_locked: (s == RUN)};
    endfunction

    state_t        state;
    flags_t        flags;
    logic [CW-1:0] cnt;
    logic          sync_ff;
    logic          lock_s;
    logic [7:0]    retry_q;
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
    logic [7:0]    loss_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 1'b0;
            lock_s  <= 1'b0;
            state   <= RESET_PLL;
            flags   <= flags_for(RESET_PLL);
            cnt     <= '0;
            retry_q <= '0;
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
            loss_q  <= '0;
`endif
        end else begin
            sync_ff <= pll_lock;
            lock_s  <= sync_ff;
            // NOTE: this default increment is overridden by any later non-blocking write to cnt below.
            cnt     <= cnt + 1'b1;
            unique case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state <= WAIT_LOCK;
                        flags <= flags_for(WAIT_LOCK);
                        cnt   <= '0;
                    end
                end
                WAIT_LOCK: begin
                    if (relock_req) begin
                        state <= RESET_PLL;
                        flags <= flags_for(RESET_PLL);
                        cnt   <= '0;
                    end else if (lock_s) begin
                        state <= STABLE;
                        flags <= flags_for(STABLE);
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state <= RESET_PLL;
                        flags <= flags_for(RESET_PLL);
                        cnt   <= '0;
                        if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
                    end
                end
                STABLE: begin
                    if (relock_req) begin
                        state <= RESET_PLL;
                        flags <= flags_for(RESET_PLL);
                        cnt   <= '0;
                    end else if (!lock_s) begin
                        state <= WAIT_LOCK;
                        flags <= flags_for(WAIT_LOCK);
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= RUN;
                        flags <= flags_for(RUN);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // In RUN the shared counter is the lock-low filter.
                    if (relock_req) begin
                        state <= RESET_PLL;
                        flags <= flags_for(RESET_PLL);
                        cnt   <= '0;
                    end else if (lock_s) begin
                        cnt <= '0;
                    end else if (cnt == DROP_LAST) begin
                        state <= RESET_PLL;
                        flags <= flags_for(RESET_PLL);
                        cnt   <= '0;
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
                        if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
`endif
                    end
                end
            endcase
        end
    end

    assign pll_rst    = flags.pll_rst;
    assign hdmi_rst   = flags.hdmi_rst;
    assign sup_locked = flags.sup_locked;
    assign sup_state  = state;
    assign retry_cnt  = retry_q;
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
    assign loss_cnt   = loss_q;
`else
    assign loss_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Self-checking bench for hdmi_pll_supervisor: directed vector table, corner-case sequences, and
// randomized lock/relock stimulus compared every cycle against a behavioural model.
module tb_hdmi_pll_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 10;
    localparam int DROP_FILTER   = 3;
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_rst;
    logic       hdmi_rst;
    logic       sup_locked;
    logic [1:0] sup_state;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int w;
    int cyc;
    int len;

    always #5 clk = ~clk;

    hdmi_pll_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .DROP_FILTER  (DROP_FILTER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .hdmi_rst  (hdmi_rst),
        .sup_locked(sup_locked),
        .sup_state (sup_state),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    task automatic check(input string name, input int idx, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, actual, expected);
        end
    endtask

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] exp_loss(input int n);
        return LOSS_EN ? 8'(n) : 8'd0;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Phase 0..3 = reset pulse, waiting for lock, qualifying lock, running.
    int m_phase, m_elapsed, m_lo, m_retry, m_loss;
    bit m_sync0, m_sync1;

    task automatic m_enter(input int p);
        m_phase   = p;
        m_elapsed = 0;
        m_lo      = 0;
    endtask

    always @(posedge clk) begin : model
        bit ls;
        ls      = m_sync1;
        m_sync1 = m_sync0;
        m_sync0 = pll_lock;
        if (rst) begin
            m_sync0 = 1'b0;
            m_sync1 = 1'b0;
            m_enter(0);
            m_retry = 0;
            m_loss  = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_elapsed++;
                    if (m_elapsed == RST_CYCLES) m_enter(1);
                end
                1: begin
                    if (relock_req) m_enter(0);
                    else if (ls) m_enter(2);
                    else begin
                        m_elapsed++;
                        if (m_elapsed == LOCK_TIMEOUT) begin
                            if (m_retry < 255) m_retry++;
                            m_enter(0);
                        end
                    end
                end
                2: begin
                    if (relock_req) m_enter(0);
                    else if (!ls) m_enter(1);
                    else begin
                        m_elapsed++;
                        if (m_elapsed == STABLE_CYCLES) m_enter(3);
                    end
                end
                default: begin
                    if (relock_req) m_enter(0);
                    else if (ls) m_lo = 0;
                    else begin
                        m_lo++;
                        if (m_lo == DROP_FILTER) begin
                            if (m_loss < 255) m_loss++;
                            m_enter(0);
                        end
                    end
                end
            endcase
        end
    end

    function automatic logic [31:0] m_outs();
        return {11'd0, m_phase == 0, m_phase != 3, m_phase == 3, 2'(m_phase), 8'(m_retry),
                exp_loss(m_loss)};
    endfunction

    always @(negedge clk)
        check("model", 0, {11'd0, pll_rst, hdmi_rst, sup_locked, sup_state, retry_cnt, loss_cnt},
              m_outs());

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       lock;
        int         edges;
        logic [1:0] st;
        logic       prst;
        logic       hrst;
        logic       lkd;
        int         loss;
    } vec_t;

    vec_t vecs[18];

    initial begin
        rst        = 1'b1;
        pll_lock   = 1'b0;
        relock_req = 1'b0;

        // Power-up, lock qualification, 2-edge glitch, then a real 5-cycle loss and relock.
        vecs[0]  = '{1, 0, 5,  2'd0, 1, 1, 0, 0};
        vecs[1]  = '{0, 0, 3,  2'd0, 1, 1, 0, 0};
        vecs[2]  = '{0, 0, 1,  2'd1, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 16, 2'd1, 0, 1, 0, 0};
        vecs[4]  = '{0, 1, 1,  2'd1, 0, 1, 0, 0};
        vecs[5]  = '{0, 1, 1,  2'd1, 0, 1, 0, 0};
        vecs[6]  = '{0, 1, 1,  2'd2, 0, 1, 0, 0};
        vecs[7]  = '{0, 1, 9,  2'd2, 0, 1, 0, 0};
        vecs[8]  = '{0, 1, 1,  2'd3, 0, 0, 1, 0};
        vecs[9]  = '{0, 0, 2,  2'd3, 0, 0, 1, 0};
        vecs[10] = '{0, 1, 5,  2'd3, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 4,  2'd3, 0, 0, 1, 0};
        vecs[12] = '{0, 0, 1,  2'd0, 1, 1, 0, 1};
        vecs[13] = '{0, 1, 3,  2'd0, 1, 1, 0, 1};
        vecs[14] = '{0, 1, 1,  2'd1, 0, 1, 0, 1};
        vecs[15] = '{0, 1, 1,  2'd2, 0, 1, 0, 1};
        vecs[16] = '{0, 1, 9,  2'd2, 0, 1, 0, 1};
        vecs[17] = '{0, 1, 1,  2'd3, 0, 0, 1, 1};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            rst      = vecs[i].rst;
            pll_lock = vecs[i].lock;
            step(vecs[i].edges);
            check("vec_state", i, sup_state, vecs[i].st);
            check("vec_pll_rst", i, pll_rst, vecs[i].prst);
            check("vec_hdmi_rst", i, hdmi_rst, vecs[i].hrst);
            check("vec_locked", i, sup_locked, vecs[i].lkd);
            check("vec_loss", i, loss_cnt, exp_loss(vecs[i].loss));
            check("vec_retry", i, retry_cnt, 0);
        end

        // Relock request on the cycle the filter would reach its limit: reset, loss not counted.
        pll_lock = 1'b0;
        step(4);
        check("relock_run_pre", 0, sup_state, 2'd3);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        check("relock_run_state", 0, sup_state, 2'd0);
        check("relock_run_loss", 0, loss_cnt, exp_loss(1));

        // Relock request inside RESET_PLL is ignored: pulse width stays RST_CYCLES.
        w = 0;
        relock_req = 1'b1;
        for (int i = 0; i < 20 && pll_rst; i++) begin
            w++;
            step(1);
            relock_req = 1'b0;
        end
        check("relock_reset_width", 0, w, RST_CYCLES);

        // Unstable lock: drop during STABLE returns to WAIT_LOCK and qualification restarts.
        pll_lock = 1'b1;
        step(2);
        check("unstable_wait", 0, sup_state, 2'd1);
        step(1);
        check("unstable_stable", 0, sup_state, 2'd2);
        step(5);
        pll_lock = 1'b0;
        step(3);
        check("unstable_back", 0, sup_state, 2'd1);
        check("unstable_hdmi", 0, hdmi_rst, 1'b1);
        pll_lock = 1'b1;
        step(3);
        check("unstable_restab", 0, sup_state, 2'd2);
        step(9);
        check("unstable_hold", 0, hdmi_rst, 1'b1);
        step(1);
        check("unstable_release", 0, hdmi_rst, 1'b0);

        // Lock timeouts: retry 1 then 2, then reset asserted from STABLE.
        rst = 1'b1;
        pll_lock = 1'b0;
        step(2);
        rst = 1'b0;
        step(4);
        check("to_pll_rst_fall", 0, pll_rst, 1'b0);
        step(99);
        check("to_wait", 0, {sup_state, retry_cnt}, {2'd1, 8'd0});
        step(1);
        check("to_first", 0, {pll_rst, sup_state, retry_cnt}, {1'b1, 2'd0, 8'd1});
        step(4);
        step(99);
        check("to_wait2", 0, {sup_state, retry_cnt}, {2'd1, 8'd1});
        step(1);
        check("to_second", 0, {pll_rst, sup_state, retry_cnt}, {1'b1, 2'd0, 8'd2});
        step(4);
        pll_lock = 1'b1;
        step(3);
        check("mid_stable", 0, {sup_state, retry_cnt}, {2'd2, 8'd2});
        rst = 1'b1;
        step(1);
        check("mid_reset", 0, {pll_rst, hdmi_rst, sup_locked, sup_state, retry_cnt, loss_cnt},
              {1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0});

        // Timeout and lock_s rising in the same cycle: lock wins, no retry counted.
        rst = 1'b0;
        pll_lock = 1'b0;
        step(101);
        check("race_wait", 0, sup_state, 2'd1);
        pll_lock = 1'b1;
        step(3);
        check("race_lock_wins", 0, {sup_state, retry_cnt}, {2'd2, 8'd0});

        // Saturation of retry_cnt after 300 timeouts.
        rst = 1'b1;
        pll_lock = 1'b0;
        step(1);
        rst = 1'b0;
        step(3 * (RST_CYCLES + LOCK_TIMEOUT));
        check("sat_three", 0, {pll_rst, retry_cnt}, {1'b1, 8'd3});
        step(297 * (RST_CYCLES + LOCK_TIMEOUT));
        check("sat_300", 0, retry_cnt, 8'd255);
        step(RST_CYCLES + LOCK_TIMEOUT);
        check("sat_301", 0, {pll_rst, retry_cnt}, {1'b1, 8'd255});

        // Randomized lock runs, glitches, relock requests and occasional resets.
        cyc = 0;
        while (cyc < 4000) begin
            pll_lock = ~pll_lock;
            if (pll_lock) len = $urandom_range(5, 60);
            else if ($urandom_range(0, 9) == 0) len = $urandom_range(100, 160);
            else len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                relock_req = ($urandom_range(0, 199) == 0);
                rst        = ($urandom_range(0, 1999) == 0);
                step(1);
                cyc++;
            end
        end
        relock_req = 1'b0;
        rst = 1'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
